// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder.
//   - state_t     : responder FSM states
//   - WORD_W      : instruction word width
//   - CNT_W       : latency counter width
//   - addr_bad()  : misaligned / out-of-range request decode
package imem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // A request is bad if it is not word aligned or its word index falls past the array.
    function automatic logic addr_bad(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(depth));
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port and one synchronous read port.
// A read and a write to the same word on one edge return the old contents.
// The array and the read register are never reset.
//   clock   : rising-edge clock
//   wr_en   : write strobe
//   wr_addr : write word index
//   wr_data : write data
//   rd_en   : read strobe; rd_data only changes when this is high
//   rd_addr : read word index
//   rd_data : registered read data
module imem_array
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Non-blocking read and write on the same edge gives read-before-write.
    always_ff @(posedge clock) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one fetch request at a time, returns the
// addressed word (or an error) LATENCY edges after the accept, and holds the
// response until the fetch side takes it. A preload write port is always live,
// including while reset is held.
//   clock      : rising-edge clock
//   reset      : synchronous, active-low reset
//   req_valid  : fetch request present
//   req_ready  : responder idle and able to accept
//   req_addr   : byte address (PC) of the request
//   resp_valid : response present
//   resp_ready : fetch side takes the response
//   resp_data  : instruction word (0 on error)
//   resp_err   : request was misaligned or out of range
//   wr_en      : preload write strobe
//   wr_addr    : preload word index
//   wr_data    : preload data
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [WORD_W-1:0]        resp_data,
    output logic                     resp_err,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WORD_W-1:0]        wr_data
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Elaboration-time parameter checks.
    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("imem_responder: LATENCY must be in 1..15");
        end
        if (DEPTH < 4 || DEPTH > 65536 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("imem_responder: DEPTH must be a power of two in 4..65536");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               ok_q, ok_d;     // response carries array data (no error)
    logic               accept;
    logic [WORD_W-1:0]  rd_data;

    imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (accept && reset),
        .rd_addr (req_addr[AW+1:2]),
        .rd_data (rd_data)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ok_q    <= ok_d;
        end
    end

    // Next-state and accept decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ok_d    = ok_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    err_d  = addr_bad(req_addr, DEPTH);
                    ok_d   = !addr_bad(req_addr, DEPTH);
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Handshake flags decode directly from the state register; the read
    // register only loads on accept, so data is stable for the whole response.
    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = err_q;
    assign resp_data  = ok_q ? rd_data : '0;

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;

    // LATENCY=2 instance
    logic        a_req_valid, a_req_ready, a_resp_valid, a_resp_ready, a_resp_err;
    logic [31:0] a_req_addr, a_resp_data;
    // LATENCY=1 instance
    logic        b_req_valid, b_req_ready, b_resp_valid, b_resp_ready, b_resp_err;
    logic [31:0] b_req_addr, b_resp_data;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_mem [256];
    logic [31:0] held;

    always #5 clock = ~clock;

    imem_responder #(.DEPTH(256), .LATENCY(2)) u_lat2 (
        .clock(clock), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_data(a_resp_data), .resp_err(a_resp_err),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    imem_responder #(.DEPTH(256), .LATENCY(1)) u_lat1 (
        .clock(clock), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_data(b_resp_data), .resp_err(b_resp_err),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int idx, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = 8'(idx);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        exp_mem[idx] = d;
    endtask

    // Issue one request on the chosen instance, measure edges to resp_valid,
    // check payload, then complete the handshake.
    task automatic fetch(input bit lat1, input logic [31:0] addr, input logic [31:0] exp_d,
                         input logic exp_e, input int exp_lat, input string tag);
        int n;
        logic v;
        if (lat1) begin
            b_req_valid = 1'b1; b_req_addr = addr; b_resp_ready = 1'b1;
        end else begin
            a_req_valid = 1'b1; a_req_addr = addr; a_resp_ready = 1'b1;
        end
        tick();
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        n = 1;
        v = lat1 ? b_resp_valid : a_resp_valid;
        while (!v && n < 20) begin
            tick();
            n++;
            v = lat1 ? b_resp_valid : a_resp_valid;
        end
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        chk({tag, "_data"}, lat1 ? b_resp_data : a_resp_data, exp_d);
        chk({tag, "_err"}, 32'(lat1 ? b_resp_err : a_resp_err), 32'(exp_e));
        tick();
        chk({tag, "_ready"}, 32'(lat1 ? b_req_ready : a_req_ready), 32'd1);
        chk({tag, "_vdone"}, 32'(lat1 ? b_resp_valid : a_resp_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        a_req_valid = 1'b0; a_req_addr = '0; a_resp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_addr = '0; b_resp_ready = 1'b0;

        // Preload while reset is held.
        for (int i = 0; i < 256; i++) begin
            wr(i, {16'hC0DE, 16'(i)});
        end
        wr(3, 32'h2002000A);
        wr(5, 32'h11111111);

        chk("rst_req_ready", 32'(a_req_ready), 32'd1);
        chk("rst_resp_valid", 32'(a_resp_valid), 32'd0);
        chk("rst_resp_data", a_resp_data, 32'd0);
        chk("rst_resp_err", 32'(a_resp_err), 32'd0);
        reset = 1'b1;
        tick();

        // Basic fetch, stepwise.
        a_req_valid = 1'b1; a_req_addr = 32'h0000000C; a_resp_ready = 1'b1;
        tick();
        a_req_valid = 1'b0;
        chk("basic_wait_ready", 32'(a_req_ready), 32'd0);
        chk("basic_wait_valid", 32'(a_resp_valid), 32'd0);
        tick();
        chk("basic_valid", 32'(a_resp_valid), 32'd1);
        chk("basic_data", a_resp_data, 32'h2002000A);
        chk("basic_err", 32'(a_resp_err), 32'd0);
        tick();
        chk("basic_idle_valid", 32'(a_resp_valid), 32'd0);
        chk("basic_idle_ready", 32'(a_req_ready), 32'd1);

        // Backpressure, with an ignored request and a write to the captured word.
        a_req_valid = 1'b1; a_req_addr = 32'h00000010; a_resp_ready = 1'b0;
        tick();
        a_req_addr = 32'h00000020;
        tick();
        chk("bp_valid", 32'(a_resp_valid), 32'd1);
        chk("bp_data", a_resp_data, 32'hC0DE0004);
        held = a_resp_data;
        wr(4, 32'h44444444);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", 32'(a_resp_valid), 32'd1);
            chk("bp_hold_data", a_resp_data, held);
            chk("bp_hold_err", 32'(a_resp_err), 32'd0);
            chk("bp_hold_ready", 32'(a_req_ready), 32'd0);
            if (i < 4) tick();
        end
        a_req_valid = 1'b0;
        a_resp_ready = 1'b1;
        tick();
        chk("bp_done_valid", 32'(a_resp_valid), 32'd0);
        chk("bp_done_ready", 32'(a_req_ready), 32'd1);
        tick();
        chk("bp_no_reaccept", 32'(a_req_ready), 32'd1);

        // Error cases and the last in-range word.
        fetch(1'b0, 32'h00000006, 32'd0, 1'b1, 2, "misalign");
        fetch(1'b0, 32'h00000400, 32'd0, 1'b1, 2, "range");
        fetch(1'b0, 32'h000003FC, 32'hC0DE00FF, 1'b0, 2, "last");
        fetch(1'b0, 32'hFFFFFFFC, 32'd0, 1'b1, 2, "high");

        // Write and accept of the same word on one edge: old data returned.
        wr_en = 1'b1; wr_addr = 8'd5; wr_data = 32'hDEADBEEF;
        a_req_valid = 1'b1; a_req_addr = 32'h00000014; a_resp_ready = 1'b0;
        tick();
        wr_en = 1'b0; a_req_valid = 1'b0;
        exp_mem[5] = 32'hDEADBEEF;
        tick();
        chk("coll_valid", 32'(a_resp_valid), 32'd1);
        chk("coll_data", a_resp_data, 32'h11111111);
        a_resp_ready = 1'b1;
        tick();
        fetch(1'b0, 32'h00000014, 32'hDEADBEEF, 1'b0, 2, "coll_after");

        // Reset one cycle into WAIT abandons the request.
        a_req_valid = 1'b1; a_req_addr = 32'h0000000C; a_resp_ready = 1'b1;
        tick();
        a_req_valid = 1'b0;
        reset = 1'b0;
        tick();
        chk("midrst_valid", 32'(a_resp_valid), 32'd0);
        chk("midrst_data", a_resp_data, 32'd0);
        chk("midrst_ready", 32'(a_req_ready), 32'd1);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst_quiet", 32'(a_resp_valid), 32'd0);
        end
        fetch(1'b0, 32'h00000008, 32'hC0DE0002, 1'b0, 2, "post_rst");

        // LATENCY=1 sequential sweep.
        for (int i = 0; i < 16; i++) begin
            fetch(1'b1, 32'(i * 4), exp_mem[i], 1'b0, 1, "sweep");
        end
        fetch(1'b1, 32'h00000401, 32'd0, 1'b1, 1, "l1_err");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter DEPTH, default 256: instruction memory size in 32-bit words (power of two, 4..65536).
REQ-002 Parameter LATENCY, default 2: cycles from request acceptance to response presentation (1..15).
REQ-003 Port clock, input, 1: rising-edge clock for all state.
REQ-004 Port reset, input, 1: synchronous, active-low reset.
REQ-005 Port req_valid, input, 1: fetch side presents a byte address.
REQ-006 Port req_ready, output, 1: responder can accept a request.
REQ-007 Port req_addr, input, 32: byte address of the requested instruction (PC value).
REQ-008 Port resp_valid, output, 1: resp_data/resp_err are valid.
REQ-009 Port resp_ready, input, 1: fetch side accepts the response.
REQ-010 Port resp_data, output, 32: instruction word.
REQ-011 Port resp_err, output, 1: request was misaligned or out of range.
REQ-012 Port wr_en, input, 1: preload write strobe.
REQ-013 Port wr_addr, input, log2(DEPTH): word index for the preload write.
REQ-014 Port wr_data, input, 32: preload data.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE (combinational decode of the state). No back-to-back acceptance.
REQ-017 In IDLE, req_valid=1 at a rising edge SHALL be an accept: capture the address, read the array, then go to RESP if LATENCY=1, otherwise go to WAIT with counter=LATENCY-1.
REQ-018 In WAIT, the counter SHALL decrement each cycle. The FSM SHALL enter RESP on the edge where the counter equals 1.
REQ-019 resp_valid SHALL be 1 exactly in RESP. It SHALL first assert LATENCY edges after the accept edge.
REQ-020 resp_data and resp_err SHALL be stable while resp_valid=1 and resp_ready=0.
REQ-021 resp_valid=1 and resp_ready=1 at a rising edge SHALL complete the handshake and return the FSM to IDLE.
REQ-022 resp_data SHALL be the array contents at word index req_addr[log2(DEPTH)+1:2], sampled at the accept edge.
REQ-023 req_addr[1:0]!=0 SHALL cause resp_err=1 and resp_data=0.
REQ-024 req_addr[31:2]>=DEPTH SHALL cause resp_err=1 and resp_data=0.
REQ-025 A response with no error SHALL have resp_err=0.
REQ-026 wr_en=1 SHALL write wr_data to word wr_addr at the rising edge, in any state.
REQ-027 When a write and an accept to the same word occur on the same edge, the response SHALL return the old data (read-before-write).
REQ-028 Writes to a word already captured for the outstanding response SHALL NOT alter resp_data.
REQ-029 req_addr and req_valid SHALL be ignored outside IDLE.

Reset
REQ-030 reset=0 at a rising edge SHALL force state IDLE, counter 0, resp_valid 0, resp_data 0 and resp_err 0. Consequently req_ready=1 from the first cycle after reset.
REQ-031 Reset during WAIT or RESP SHALL abandon the outstanding request with no response issued.
REQ-032 Memory array contents SHALL NOT be reset.
REQ-033 While reset=0, wr_en SHALL be honoured so that preload can occur during reset.

Structure
REQ-034 Package imem_pkg SHALL hold the FSM state enum (IDLE, WAIT, RESP) and the 32-bit word width constant.
REQ-035 Storage SHALL be a sub-module imem_array: synchronous write and read port, read-before-write, no reset.
REQ-036 The counter width SHALL be 4 bits, with LATENCY range-checked at elaboration.

Verification
REQ-037 Basic fetch: preload word 3 = 0x2002000A, LATENCY=2, request addr 0x0000000C, resp_ready=1 -> resp_valid 2 edges after accept, data 0x2002000A, err 0, req_ready back to 1 the next cycle.
REQ-038 Backpressure: resp_ready held 0 for 5 cycles -> resp_valid, resp_data and resp_err stay constant and req_ready stays 0. On raising resp_ready -> one handshake, then IDLE.
REQ-039 Errors, DEPTH=256: addr 0x00000006 -> err 1, data 0. Addr 0x00000400 -> err 1, data 0. Addr 0x000003FC -> err 0, returns word 255.
REQ-040 Collision: write 0xDEADBEEF to word 5 on the same edge as accepting addr 0x14 (old value 0x11111111) -> response 0x11111111. A subsequent fetch of 0x14 -> 0xDEADBEEF.
REQ-041 Reset mid-operation: assert reset=0 one cycle into WAIT -> no resp_valid ever for that request, and resp_data=0. After release, a new request completes normally.
REQ-042 LATENCY=1: accept -> resp_valid on the next edge. Sweep of sequential PCs 0x0..0x3C returns the preloaded words in order.
